// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Multi-read, dual-write register file with same-cycle write
//            bypass and a per-register busy scoreboard for hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr_i,
  output logic [NREAD*DATA_W-1:0]  rd_data_o,
  output logic [NREAD-1:0]         src_busy_o,
  input  logic                     we0_i,
  input  logic                     we1_i,
  input  logic [ADDR_W-1:0]        wa0_i,
  input  logic [ADDR_W-1:0]        wa1_i,
  input  logic [DATA_W-1:0]        wd0_i,
  input  logic [DATA_W-1:0]        wd1_i,
  input  logic                     iss_valid_i,
  input  logic [ADDR_W-1:0]        iss_rd_i,
  output logic                     iss_hazard_o,
  output logic [(1<<ADDR_W)-1:0]   busy_vec_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DEPTH-1:0]  w_clr;
  logic [DEPTH-1:0]  w_busy_eff;
  logic              w_wr0_ok;
  logic              w_wr1_ok;
  logic              w_accept;

  assign w_wr0_ok = we0_i && !(ZR && (wa0_i == '0));
  assign w_wr1_ok = we1_i && !(ZR && (wa1_i == '0));

  always_comb begin
    w_clr = '0;
    for (int r = 0; r < DEPTH; r++) begin
      w_clr[r] = (we0_i && (wa0_i == ADDR_W'(r))) || (we1_i && (wa1_i == ADDR_W'(r)));
    end
  end

  // A same-cycle write-back resolves the hazard since its value is bypassed.
  assign w_busy_eff = busy_q & ~w_clr;

  logic [DATA_W-1:0] w_rdata [NREAD];

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = rd_addr_i[g*ADDR_W +: ADDR_W];

    always_comb begin
      w_rdata[g] = mem_q[w_ra];
      if (ZR && (w_ra == '0)) begin
        w_rdata[g] = '0;
      end else if (we1_i && (wa1_i == w_ra)) begin
        w_rdata[g] = wd1_i;
      end else if (we0_i && (wa0_i == w_ra)) begin
        w_rdata[g] = wd0_i;
      end
    end

    assign rd_data_o[g*DATA_W +: DATA_W] = w_rdata[g];
    assign src_busy_o[g] = w_busy_eff[w_ra] && !(ZR && (w_ra == '0));
  end

  assign iss_hazard_o = iss_valid_i && (w_busy_eff[iss_rd_i] || (|src_busy_o));
  assign w_accept     = iss_valid_i && !iss_hazard_o && !(ZR && (iss_rd_i == '0));

  // Set beats clear: a newly accepted producer supersedes the retiring one.
  always_comb begin
    busy_d = busy_q & ~w_clr;
    if (w_accept) begin
      busy_d[iss_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Port 1 is written last so it wins an address collision with port 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      if (w_wr0_ok) mem_q[wa0_i] <= wd0_i;
      if (w_wr1_ok) mem_q[wa1_i] <= wd1_i;
    end
  end

  assign busy_vec_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Self-checking bench for regfile_sb against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  src_busy;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_hazard;
  logic [31:0] busy_vec;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .src_busy_o  (src_busy),
    .we0_i       (we0),
    .we1_i       (we1),
    .wa0_i       (wa0),
    .wa1_i       (wa1),
    .wd0_i       (wd0),
    .wd1_i       (wd1),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .iss_hazard_o(iss_hazard),
    .busy_vec_o  (busy_vec)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Value an operand read of register a should return this cycle.
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0)             return 32'd0;
    if (we1 && wa1 == a)       return wd1;
    if (we0 && wa0 == a)       return wd0;
    return m_mem[a];
  endfunction

  // A register is still a hazard unless written back this very cycle.
  function automatic bit m_pending(input logic [4:0] a);
    return m_busy[a] && !((we0 && wa0 == a) || (we1 && wa1 == a));
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic idle();
    reset = 0; rd_addr = '0; we0 = 0; we1 = 0; wa0 = '0; wa1 = '0;
    wd0 = '0; wd1 = '0; iss_valid = 0; iss_rd = '0;
  endtask

  // Inputs are applied after a negedge; check, then advance one clock.
  task automatic cycle();
    logic [4:0] a [2];
    bit         sb [2];
    bit         haz;
    #1;
    for (int i = 0; i < 2; i++) begin
      a[i]  = rd_addr[i*5 +: 5];
      sb[i] = (a[i] != 5'd0) && m_pending(a[i]);
      check($sformatf("rd_data%0d", i), 64'(rd_data[i*32 +: 32]), 64'(m_read(a[i])));
    end
    haz = iss_valid && (m_pending(iss_rd) || sb[0] || sb[1]);
    check("src_busy", 64'(src_busy), 64'({sb[1], sb[0]}));
    check("iss_hazard", 64'(iss_hazard), 64'(haz));
    check("busy_vec", 64'(busy_vec), 64'(m_busy_vec()));
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 32; r++) begin m_mem[r] = '0; m_busy[r] = 0; end
    end else begin
      if (we0) m_busy[wa0] = 0;
      if (we1) m_busy[wa1] = 0;
      if (we0 && wa0 != 0) m_mem[wa0] = wd0;
      if (we1 && wa1 != 0) m_mem[wa1] = wd1;
      if (iss_valid && !haz && iss_rd != 0) m_busy[iss_rd] = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin m_mem[r] = '0; m_busy[r] = 0; end
    idle();
    reset = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 0;

    // Post-reset sweep of every register on both ports.
    for (int r = 0; r < 32; r++) begin
      rd_addr = {5'(31 - r), 5'(r)};
      #1 check("reset_rd0", 64'(rd_data[31:0]), 64'd0);
      cycle();
    end
    check("reset_busy", 64'(busy_vec), 64'd0);

    // Bypass then array read of r5.
    idle(); we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    #1 check("bypass_r5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    cycle();
    idle(); rd_addr = {5'd0, 5'd5};
    #1 check("array_r5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    cycle();

    // Write collision: port 1 wins; r0 stays zero.
    idle(); we0 = 1; wa0 = 5'd7; wd0 = 32'h11; we1 = 1; wa1 = 5'd7; wd1 = 32'h22;
    rd_addr = {5'd7, 5'd0};
    #1 check("collide_bypass", 64'(rd_data[63:32]), 64'h22);
    cycle();
    idle(); rd_addr = {5'd7, 5'd0};
    #1 check("collide_array", 64'(rd_data[63:32]), 64'h22);
    cycle();
    idle(); we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFF; rd_addr = {5'd0, 5'd0};
    #1 check("r0_bypass", 64'(rd_data[31:0]), 64'd0);
    cycle();
    idle();
    #1 check("r0_array", 64'(rd_data[31:0]), 64'd0);
    cycle();

    // RAW hazard on r3 resolved by a write-back bypass.
    idle(); iss_valid = 1; iss_rd = 5'd3;
    cycle();
    idle(); iss_valid = 1; iss_rd = 5'd10; rd_addr = {5'd3, 5'd0};
    #1 check("raw_src_busy", 64'(src_busy[1]), 64'd1);
    check("raw_hazard", 64'(iss_hazard), 64'd1);
    cycle();
    idle(); iss_valid = 1; iss_rd = 5'd10; rd_addr = {5'd3, 5'd0};
    we1 = 1; wa1 = 5'd3; wd1 = 32'h55;
    #1 check("wb_src_busy", 64'(src_busy[1]), 64'd0);
    check("wb_rd1", 64'(rd_data[63:32]), 64'h55);
    check("wb_hazard", 64'(iss_hazard), 64'd0);
    cycle();
    idle();
    #1 check("r10_busy", 64'(busy_vec[10]), 64'd1);
    check("r3_clear", 64'(busy_vec[3]), 64'd0);
    cycle();

    // Set beats clear on r9, then WAW on busy r9.
    idle(); iss_valid = 1; iss_rd = 5'd9;
    cycle();
    idle(); iss_valid = 1; iss_rd = 5'd9; we0 = 1; wa0 = 5'd9; wd0 = 32'h99;
    #1 check("r9_reissue_ok", 64'(iss_hazard), 64'd0);
    cycle();
    idle(); iss_valid = 1; iss_rd = 5'd9;
    #1 check("r9_still_busy", 64'(busy_vec[9]), 64'd1);
    check("waw_hazard", 64'(iss_hazard), 64'd1);
    cycle();

    // Reset clears pending busy bits and data.
    idle(); iss_valid = 1; iss_rd = 5'd2; cycle();
    idle(); iss_valid = 1; iss_rd = 5'd4; cycle();
    idle(); reset = 1; we0 = 1; wa0 = 5'd6; wd0 = 32'h66; cycle();
    idle();
    #1 check("rst_busy_vec", 64'(busy_vec), 64'd0);
    for (int r = 0; r < 32; r += 2) begin
      rd_addr = {5'(r + 1), 5'(r)};
      #1 check("rst_rd", 64'(rd_data), 64'd0);
      cycle();
    end

    // Randomized traffic on a narrow address window to force collisions.
    for (int n = 0; n < 600; n++) begin
      idle();
      reset     = ($urandom_range(0, 79) == 0);
      rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      we0       = ($urandom_range(0, 2) == 0);
      we1       = ($urandom_range(0, 2) == 0);
      wa0       = 5'($urandom_range(0, 7));
      wa1       = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wd0       = $urandom;
      wd1       = $urandom;
      iss_valid = ($urandom_range(0, 1) == 0);
      iss_rd    = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
